// File: rtl/cpu_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_sequencer
//   Instruction sequencer for a small CPU core. It moves through FETCH, a
//   one- or two-cycle execute phase and then back to FETCH. The HALT and
//   PAUSE states add halt/resume and single-step control. It also counts
//   active cycles and completed instructions.
//
// Ports
//   clock        in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   sm_extra     in   decoder asks for a second execute cycle (EXEC1 only)
//   stop         in   halt request, level (stack overflow / STP)
//   mem_ready    in   instruction RAM read complete (FETCH only)
//   step_mode    in   1 = single-step, 0 = free run
//   step         in   pulse, releases one instruction from PAUSE
//   resume       in   pulse, leaves HALT
//   state[1:0]   out  FETCH=00, EXEC1=10, EXEC2=01, HALT/PAUSE=11
//   halted       out  1 while in HALT
//   paused       out  1 while in PAUSE
//   instr_done   out  1 in the last execute cycle of each instruction
//   cycle_count  out  active (FETCH/EXEC1/EXEC2) cycle count, wraps
//   instr_count  out  completed instruction count, wraps
// ---------------------------------------------------------------------------
module cpu_sequencer (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        sm_extra,
   input  logic        stop,
   input  logic        mem_ready,
   input  logic        step_mode,
   input  logic        step,
   input  logic        resume,
   output logic [1:0]  state,
   output logic        halted,
   output logic        paused,
   output logic        instr_done,
   output logic [15:0] cycle_count,
   output logic [15:0] instr_count
);

   localparam int unsigned CNT_W  = 16;
   localparam int unsigned CODE_W = 2;

   typedef enum logic [2:0] {
      S_FETCH = 3'd0,
      S_EXEC1 = 3'd1,
      S_EXEC2 = 3'd2,
      S_HALT  = 3'd3,
      S_PAUSE = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic                r_stop_pending;
   logic                w_active;
   logic                w_boundary;
   logic [CODE_W-1:0]   w_code;
   logic [CODE_W-1:0]   r_code;
   logic                r_halted;
   logic                r_paused;
   logic [CNT_W-1:0]    r_cycle_count;
   logic [CNT_W-1:0]    r_instr_count;

   // State register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state decode. An instruction boundary is resolved after the
   // per-state transition so that stop/step_mode priority applies in one place.
   always_comb begin
      w_next     = r_state;
      w_active   = 1'b0;
      w_boundary = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_active = 1'b1;
            if (mem_ready) w_next = S_EXEC1;
         end
         S_EXEC1: begin
            w_active = 1'b1;
            if (sm_extra) w_next = S_EXEC2;
            else          w_boundary = 1'b1;
         end
         S_EXEC2: begin
            w_active   = 1'b1;
            w_boundary = 1'b1;
         end
         S_HALT: begin
            if (resume && !stop) w_next = S_FETCH;
         end
         S_PAUSE: begin
            if (stop)                    w_next = S_HALT;
            else if (step || !step_mode) w_next = S_FETCH;
         end
         default: w_next = S_FETCH;
      endcase

      if (w_boundary) begin
         if (stop || r_stop_pending) w_next = S_HALT;
         else if (step_mode)         w_next = S_PAUSE;
         else                        w_next = S_FETCH;
      end
   end

   // Decoder-facing encoding of the upcoming state
   always_comb begin
      w_code = 2'b00;
      case (w_next)
         S_FETCH: w_code = 2'b00;
         S_EXEC1: w_code = 2'b10;
         S_EXEC2: w_code = 2'b01;
         S_HALT:  w_code = 2'b11;
         S_PAUSE: w_code = 2'b11;
         default: w_code = 2'b00;
      endcase
   end

   // Registered status outputs, loaded with the decode of the next state
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_code   <= 2'b00;
         r_halted <= 1'b0;
         r_paused <= 1'b0;
      end else begin
         r_code   <= w_code;
         r_halted <= (w_next == S_HALT);
         r_paused <= (w_next == S_PAUSE);
      end
   end

   // Latched stop request. Any stop during an instruction lets that
   // instruction finish. Entering HALT consumes the request.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_stop_pending <= 1'b0;
      end else if (w_next == S_HALT) begin
         r_stop_pending <= 1'b0;
      end else if (w_active && stop) begin
         r_stop_pending <= 1'b1;
      end
   end

   // Activity counters, free-running wrap
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_cycle_count <= '0;
         r_instr_count <= '0;
      end else begin
         if (w_active)   r_cycle_count <= r_cycle_count + CNT_W'(1);
         if (w_boundary) r_instr_count <= r_instr_count + CNT_W'(1);
      end
   end

   assign state       = r_code;
   assign halted      = r_halted;
   assign paused      = r_paused;
   // The EXEC1 boundary depends on sm_extra in the same cycle, so this
   // flag is decoded from the state register and sm_extra.
   assign instr_done  = w_boundary;
   assign cycle_count = r_cycle_count;
   assign instr_count = r_instr_count;

endmodule

// File: tb/tb_cpu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cpu_sequencer
//   Applies table-driven vectors to cpu_sequencer. Each record holds the
//   inputs for one cycle and the outputs expected in that cycle. The
//   expected outputs go onto a scoreboard queue when the inputs are driven.
//   They come off the queue and are compared at the falling edge.
// ---------------------------------------------------------------------------
module tb_cpu_sequencer;

   typedef struct {
      logic        mr;
      logic        sx;
      logic        stp;
      logic        sm;
      logic        stepp;
      logic        res;
      logic [1:0]  e_state;
      logic        e_done;
      logic        e_halt;
      logic        e_pause;
      logic [15:0] e_cc;
      logic [15:0] e_ic;
   } vec_t;

   logic        clock;
   logic        reset_n;
   logic        sm_extra;
   logic        stop;
   logic        mem_ready;
   logic        step_mode;
   logic        step;
   logic        resume;
   logic [1:0]  state;
   logic        halted;
   logic        paused;
   logic        instr_done;
   logic [15:0] cycle_count;
   logic [15:0] instr_count;

   int checks   = 0;
   int failures = 0;
   vec_t exp_q[$];

   cpu_sequencer dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .sm_extra    (sm_extra),
      .stop        (stop),
      .mem_ready   (mem_ready),
      .step_mode   (step_mode),
      .step        (step),
      .resume      (resume),
      .state       (state),
      .halted      (halted),
      .paused      (paused),
      .instr_done  (instr_done),
      .cycle_count (cycle_count),
      .instr_count (instr_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   function automatic vec_t mk(input logic mr, input logic sx, input logic stp,
                               input logic sm, input logic stepp, input logic res,
                               input logic [1:0] st, input logic done,
                               input logic h, input logic p,
                               input logic [15:0] cc, input logic [15:0] ic);
      vec_t v;
      v.mr = mr; v.sx = sx; v.stp = stp; v.sm = sm; v.stepp = stepp; v.res = res;
      v.e_state = st; v.e_done = done; v.e_halt = h; v.e_pause = p;
      v.e_cc = cc; v.e_ic = ic;
      return v;
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input vec_t v);
      mem_ready = v.mr;
      sm_extra  = v.sx;
      stop      = v.stp;
      step_mode = v.sm;
      step      = v.stepp;
      resume    = v.res;
   endtask

   // Drive one record, push its expectation, compare at the falling edge
   task automatic apply_cycle(input string tag, input vec_t v, input bit advance);
      vec_t e;
      drive(v);
      exp_q.push_back(v);
      @(negedge clock);
      e = exp_q.pop_front();
      check({tag, ".state"},      16'(state),       16'(e.e_state));
      check({tag, ".instr_done"}, 16'(instr_done),  16'(e.e_done));
      check({tag, ".halted"},     16'(halted),      16'(e.e_halt));
      check({tag, ".paused"},     16'(paused),      16'(e.e_pause));
      check({tag, ".cycle_count"}, cycle_count,     e.e_cc);
      check({tag, ".instr_count"}, instr_count,     e.e_ic);
      if (advance) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic run_vecs(input string tag, input vec_t vs[$]);
      for (int i = 0; i < vs.size(); i++) begin
         apply_cycle($sformatf("%s[%0d]", tag, i), vs[i], 1'b1);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, ".state"},       16'(state),      16'h0000);
      check({tag, ".halted"},      16'(halted),     16'h0000);
      check({tag, ".paused"},      16'(paused),     16'h0000);
      check({tag, ".instr_done"},  16'(instr_done), 16'h0000);
      check({tag, ".cycle_count"}, cycle_count,     16'h0000);
      check({tag, ".instr_count"}, instr_count,     16'h0000);
   endtask

   // Reset, called at posedge+1. Releases reset away from the edge.
   task automatic do_reset(input string tag);
      reset_n   = 1'b0;
      mem_ready = 1'b0; sm_extra = 1'b0; stop = 1'b0;
      step_mode = 1'b0; step = 1'b0; resume = 1'b0;
      #1;
      check_reset_values(tag);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
   endtask

   vec_t va[$];
   vec_t vb[$];
   vec_t vc[$];
   vec_t vd[$];
   vec_t ve[$];

   initial begin
      // Free run, single-cycle instructions; stray resume/step ignored
      va = '{
         mk(1,0,0,0,0,0, 2'b00,0,0,0, 16'd0, 16'd0),
         mk(1,0,0,0,0,1, 2'b10,1,0,0, 16'd1, 16'd0),
         mk(1,0,0,0,1,0, 2'b00,0,0,0, 16'd2, 16'd1),
         mk(1,0,0,0,0,0, 2'b10,1,0,0, 16'd3, 16'd1),
         mk(1,0,0,0,0,0, 2'b00,0,0,0, 16'd4, 16'd2),
         mk(1,0,0,0,0,0, 2'b10,1,0,0, 16'd5, 16'd2),
         mk(0,0,0,0,0,0, 2'b00,0,0,0, 16'd6, 16'd3)
      };
      // Two FETCH wait states and a two-cycle execute
      vb = '{
         mk(0,0,0,0,0,0, 2'b00,0,0,0, 16'd0, 16'd0),
         mk(0,0,0,0,0,0, 2'b00,0,0,0, 16'd1, 16'd0),
         mk(1,0,0,0,0,0, 2'b00,0,0,0, 16'd2, 16'd0),
         mk(0,1,0,0,0,0, 2'b10,0,0,0, 16'd3, 16'd0),
         mk(0,0,0,0,0,0, 2'b01,1,0,0, 16'd4, 16'd0),
         mk(0,0,0,0,0,0, 2'b00,0,0,0, 16'd5, 16'd1)
      };
      // Stop pulse in FETCH, instruction completes, HALT, blocked and real resume
      vc = '{
         mk(1,0,1,0,0,0, 2'b00,0,0,0, 16'd0, 16'd0),
         mk(1,1,0,0,0,0, 2'b10,0,0,0, 16'd1, 16'd0),
         mk(0,0,0,0,0,0, 2'b01,1,0,0, 16'd2, 16'd0),
         mk(0,0,0,0,1,0, 2'b11,0,1,0, 16'd3, 16'd1),
         mk(0,0,1,0,0,1, 2'b11,0,1,0, 16'd3, 16'd1),
         mk(0,0,0,0,0,0, 2'b11,0,1,0, 16'd3, 16'd1),
         mk(0,0,0,0,0,1, 2'b11,0,1,0, 16'd3, 16'd1),
         mk(0,0,0,0,0,0, 2'b00,0,0,0, 16'd3, 16'd1),
         mk(0,0,0,0,0,0, 2'b00,0,0,0, 16'd4, 16'd1)
      };
      // Single step: PAUSE, step, step ignored in EXEC1, stop beats step,
      // leaving PAUSE by clearing step_mode
      vd = '{
         mk(1,0,0,1,0,0, 2'b00,0,0,0, 16'd0, 16'd0),
         mk(1,0,0,1,0,0, 2'b10,1,0,0, 16'd1, 16'd0),
         mk(1,0,0,1,0,0, 2'b11,0,0,1, 16'd2, 16'd1),
         mk(1,0,0,1,1,0, 2'b11,0,0,1, 16'd2, 16'd1),
         mk(1,0,0,1,0,0, 2'b00,0,0,0, 16'd2, 16'd1),
         mk(1,0,0,1,1,0, 2'b10,1,0,0, 16'd3, 16'd1),
         mk(1,0,0,1,0,0, 2'b11,0,0,1, 16'd4, 16'd2),
         mk(1,0,1,1,1,0, 2'b11,0,0,1, 16'd4, 16'd2),
         mk(1,0,0,0,0,1, 2'b11,0,1,0, 16'd4, 16'd2),
         mk(1,0,0,0,0,0, 2'b00,0,0,0, 16'd4, 16'd2),
         mk(1,0,0,0,0,0, 2'b10,1,0,0, 16'd5, 16'd2),
         mk(1,0,0,1,0,0, 2'b00,0,0,0, 16'd6, 16'd3),
         mk(1,0,0,1,0,0, 2'b10,1,0,0, 16'd7, 16'd3),
         mk(1,0,0,0,0,0, 2'b11,0,0,1, 16'd8, 16'd4),
         mk(0,0,0,0,0,0, 2'b00,0,0,0, 16'd8, 16'd4)
      };
      // Cycle counter wrap across a two-cycle instruction
      ve = '{
         mk(1,0,0,0,0,0, 2'b00,0,0,0, 16'hFFFE, 16'd0),
         mk(1,1,0,0,0,0, 2'b10,0,0,0, 16'hFFFF, 16'd0)
      };

      reset_n   = 1'b0;
      mem_ready = 1'b0; sm_extra = 1'b0; stop = 1'b0;
      step_mode = 1'b0; step = 1'b0; resume = 1'b0;
      @(posedge clock);
      #1;

      do_reset("rst0");
      run_vecs("freerun", va);
      do_reset("rst1");
      run_vecs("extra", vb);
      do_reset("rst2");
      run_vecs("halt", vc);
      step_mode = 1'b1;
      do_reset("rst3");
      run_vecs("step", vd);

      do_reset("rst4");
      mem_ready = 1'b0;
      repeat (65534) @(posedge clock);
      #1;
      run_vecs("wrap", ve);
      // EXEC2 cycle with wrapped count, then async reset mid-instruction
      apply_cycle("wrap[2]", mk(0,0,0,0,0,0, 2'b01,1,0,0, 16'h0000, 16'd0), 1'b0);
      #1;
      reset_n = 1'b0;
      #1;
      check_reset_values("async_rst");
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      apply_cycle("post_rst", mk(1,0,0,1,0,0, 2'b00,0,0,0, 16'd0, 16'd0), 1'b1);
      apply_cycle("post_rst2", mk(0,0,0,1,0,0, 2'b10,1,0,0, 16'd1, 16'd0), 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
